// File: rtl/seg_scan_capture.sv
// Rebuilds the 4-digit hex word shown on a multiplexed, active-low seven-segment display.
// Each digit must dwell stably before capture; complete frames are strobed out, stale partial frames time out.
module seg_scan_capture #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        a_i,
  input  logic        b_i,
  input  logic        c_i,
  input  logic        d_i,
  input  logic        e_i,
  input  logic        f_i,
  input  logic        g_i,
  input  logic [3:0]  A_i,
  input  logic        err_clr_i,
  output logic [15:0] frame_value_o,
  output logic        frame_valid_o,
  output logic [3:0]  digit_seen_o,
  output logic        decode_err_o,
  output logic        timeout_o
);

  typedef enum logic {SETTLING, HELD} state_t;

  state_t      state_q, state_d;
  logic [10:0] cur_q, prev_q;
  logic [7:0]  stab_q, stab_d;
  logic [15:0] idle_q, idle_d;
  logic [3:0]  seen_q, seen_d;
  logic [15:0] frame_q, frame_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        tmo_q, tmo_d;
  logic [3:0]  slot_q [4];
  logic [15:0] slot_flat;

  logic        stable, eval, capture, anode_err, seg_err, complete, tmo_hit;
  logic [3:0]  anode, cap_mask, nib;
  logic [6:0]  seg;
  logic        seg_ok;

  function automatic logic [4:0] decode7(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40: r = 5'h10;  7'h79: r = 5'h11;  7'h24: r = 5'h12;  7'h30: r = 5'h13;
      7'h19: r = 5'h14;  7'h12: r = 5'h15;  7'h02: r = 5'h16;  7'h78: r = 5'h17;
      7'h00: r = 5'h18;  7'h10: r = 5'h19;  7'h08: r = 5'h1A;  7'h03: r = 5'h1B;
      7'h46: r = 5'h1C;  7'h21: r = 5'h1D;  7'h06: r = 5'h1E;  7'h0E: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  assign anode = cur_q[10:7];
  assign seg   = cur_q[6:0];
  assign {seg_ok, nib} = decode7(seg);

  always_comb begin
    stable  = (cur_q == prev_q);
    stab_d  = 8'd0;
    if (stable) stab_d = (stab_q == 8'(SETTLE_CYCLES)) ? stab_q : stab_q + 8'd1;

    state_d = state_q;
    eval    = 1'b0;
    case (state_q)
      SETTLING: if (stable && stab_d == 8'(SETTLE_CYCLES)) begin
        eval    = 1'b1;
        state_d = HELD;
      end
      HELD: if (!stable) state_d = SETTLING;
      default: state_d = SETTLING;
    endcase

    // Anodes are active-low, so a legal digit select is one-hot in ~anode.
    capture   = eval && $onehot(~anode);
    anode_err = eval && (anode != 4'hF) && !$onehot(~anode);
    seg_err   = capture && !seg_ok;
    cap_mask  = capture ? ~anode : 4'b0000;

    complete  = (seen_q == 4'hF);
    tmo_hit   = (idle_q == 16'(TIMEOUT_CYCLES)) && !capture && !complete;

    seen_d = seen_q | cap_mask;
    if (complete)     seen_d = cap_mask;
    else if (tmo_hit) seen_d = 4'b0000;

    idle_d = 16'd0;
    if (!(capture || complete || tmo_hit) && seen_q != 4'b0000) idle_d = idle_q + 16'd1;

    err_d = err_q;
    if (anode_err || seg_err) err_d = 1'b1;
    else if (err_clr_i)       err_d = 1'b0;

    valid_d = complete;
    frame_d = complete ? slot_flat : frame_q;
    tmo_d   = tmo_hit;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= SETTLING;
      cur_q   <= '1;
      prev_q  <= '1;
      stab_q  <= '0;
      idle_q  <= '0;
      seen_q  <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= {A_i, g_i, f_i, e_i, d_i, c_i, b_i, a_i};
      prev_q  <= cur_q;
      stab_q  <= stab_d;
      idle_q  <= idle_d;
      seen_q  <= seen_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      always_ff @(posedge clk_i) begin
        if (reset_i)           slot_q[gi] <= 4'h0;
        else if (cap_mask[gi]) slot_q[gi] <= nib;
      end
      assign slot_flat[4*gi +: 4] = slot_q[gi];
    end
  endgenerate

  assign frame_value_o = frame_q;
  assign frame_valid_o = valid_q;
  assign digit_seen_o  = seen_q;
  assign decode_err_o  = err_q;
  assign timeout_o     = tmo_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: frames, glitches, illegal patterns, timeout and mid-frame reset.
module tb_seg_scan_capture;

  logic        clk, reset, a, b, c, d, e, f, g, err_clr;
  logic [3:0]  A;
  logic [15:0] frame_value;
  logic        frame_valid, decode_err, timeout;
  logic [3:0]  digit_seen;

  int total = 0;
  int bad   = 0;
  int fv_cnt = 0, to_cnt = 0, both_cnt = 0;
  int fv0, to0;

  seg_scan_capture #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
    .clk_i(clk), .reset_i(reset),
    .a_i(a), .b_i(b), .c_i(c), .d_i(d), .e_i(e), .f_i(f), .g_i(g),
    .A_i(A), .err_clr_i(err_clr),
    .frame_value_o(frame_value), .frame_valid_o(frame_valid),
    .digit_seen_o(digit_seen), .decode_err_o(decode_err), .timeout_o(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse counters sampled mid-cycle; the number of high samples equals the pulse width.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_cnt++;
    if (timeout === 1'b1) to_cnt++;
    if (frame_valid === 1'b1 && timeout === 1'b1) both_cnt++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] sg);
    A = an;
    {g, f, e, d, c, b, a} = sg;
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] sg, input int n);
    drive(an, sg);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    err_clr = 1'b0;
    drive(4'hF, 7'h7F);
    repeat (3) @(negedge clk);
    chk("rst_value", frame_value, 16'h0000);
    chk("rst_valid", 16'(frame_valid), 16'h0);
    chk("rst_seen", 16'(digit_seen), 16'h0);
    chk("rst_err", 16'(decode_err), 16'h0);
    chk("rst_tmo", 16'(timeout), 16'h0);
    reset = 1'b0;

    // Normal frame: 1,2,3,4 on digits 0..3
    fv0 = fv_cnt;
    hold(4'b1110, 7'h79, 8);
    hold(4'b1101, 7'h24, 8);
    hold(4'b1011, 7'h30, 8);
    hold(4'b0111, 7'h19, 8);
    hold(4'b1111, 7'h7F, 2);
    chk("norm_fv_count", 16'(fv_cnt - fv0), 16'd1);
    chk("norm_value", frame_value, 16'h4321);
    chk("norm_err", 16'(decode_err), 16'h0);
    chk("norm_seen", 16'(digit_seen), 16'h0);
    chk("norm_no_tmo", 16'(to_cnt), 16'd0);

    // Glitch rejection: 4-cycle dwell ignored, 5-cycle dwell captured
    hold(4'b1110, 7'h40, 4);
    hold(4'b1111, 7'h7F, 10);
    chk("glitch_seen", 16'(digit_seen), 16'h0);
    hold(4'b1110, 7'h40, 5);
    hold(4'b1111, 7'h7F, 2);
    chk("dwell5_seen", 16'(digit_seen), 16'h1);
    hold(4'b1111, 7'h7F, 25);
    chk("dwell5_tmo_count", 16'(to_cnt), 16'd1);
    chk("dwell5_tmo_seen", 16'(digit_seen), 16'h0);

    // Illegal segment pattern stores 0 and flags an error
    fv0 = fv_cnt;
    hold(4'b1110, 7'h7F, 8);
    chk("badseg_err", 16'(decode_err), 16'h1);
    chk("badseg_seen", 16'(digit_seen), 16'h1);
    pulse_clr();
    chk("badseg_clr", 16'(decode_err), 16'h0);
    hold(4'b1101, 7'h79, 8);
    hold(4'b1011, 7'h24, 8);
    hold(4'b0111, 7'h30, 8);
    hold(4'b1111, 7'h7F, 3);
    chk("badseg_frame", frame_value, 16'h3210);
    chk("badseg_fv_count", 16'(fv_cnt - fv0), 16'd1);
    chk("badseg_after_err", 16'(decode_err), 16'h0);

    // Illegal anode pattern: error without capture
    hold(4'b1110, 7'h40, 8);
    hold(4'b1100, 7'h00, 8);
    chk("badan_err", 16'(decode_err), 16'h1);
    chk("badan_seen", 16'(digit_seen), 16'h1);
    pulse_clr();
    chk("badan_clr", 16'(decode_err), 16'h0);
    hold(4'b1111, 7'h7F, 25);
    chk("badan_tmo_count", 16'(to_cnt), 16'd2);

    // Timeout boundary: idle count reaches 20 after the last capture
    to0 = to_cnt;
    fv0 = fv_cnt;
    hold(4'b1110, 7'h79, 8);
    hold(4'b1101, 7'h24, 8);
    hold(4'b1111, 7'h7F, 18);
    chk("tmo_before", 16'(timeout), 16'h0);
    chk("tmo_before_seen", 16'(digit_seen), 16'h3);
    @(negedge clk);
    chk("tmo_pulse", 16'(timeout), 16'h1);
    chk("tmo_seen", 16'(digit_seen), 16'h0);
    @(negedge clk);
    chk("tmo_one_cycle", 16'(timeout), 16'h0);
    chk("tmo_count", 16'(to_cnt - to0), 16'd1);
    chk("tmo_no_frame", 16'(fv_cnt - fv0), 16'd0);
    hold(4'b1110, 7'h0E, 8);
    hold(4'b1101, 7'h06, 8);
    hold(4'b1011, 7'h21, 8);
    hold(4'b0111, 7'h46, 8);
    hold(4'b1111, 7'h7F, 3);
    chk("cdef_value", frame_value, 16'hCDEF);
    chk("cdef_fv_count", 16'(fv_cnt - fv0), 16'd1);

    // Reset mid-frame after three captures and an error
    hold(4'b1110, 7'h00, 8);
    hold(4'b1101, 7'h10, 8);
    hold(4'b1011, 7'h08, 8);
    chk("mid_seen", 16'(digit_seen), 16'h7);
    hold(4'b1001, 7'h00, 8);
    chk("mid_err", 16'(decode_err), 16'h1);
    reset = 1'b1;
    drive(4'hF, 7'h7F);
    @(negedge clk);
    chk("mid_rst_value", frame_value, 16'h0000);
    chk("mid_rst_valid", 16'(frame_valid), 16'h0);
    chk("mid_rst_seen", 16'(digit_seen), 16'h0);
    chk("mid_rst_err", 16'(decode_err), 16'h0);
    chk("mid_rst_tmo", 16'(timeout), 16'h0);
    reset = 1'b0;
    fv0 = fv_cnt;
    hold(4'b0111, 7'h12, 8);
    chk("post_rst_seen", 16'(digit_seen), 16'h8);
    chk("post_rst_no_frame", 16'(fv_cnt - fv0), 16'd0);
    hold(4'b1110, 7'h02, 8);
    hold(4'b1101, 7'h78, 8);
    hold(4'b1011, 7'h03, 8);
    hold(4'b1111, 7'h7F, 3);
    chk("post_rst_value", frame_value, 16'h5B76);
    chk("post_rst_fv_count", 16'(fv_cnt - fv0), 16'd1);
    chk("post_rst_seen_clr", 16'(digit_seen), 16'h0);
    chk("never_both_strobes", 16'(both_cnt), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
